prbs_gen_chk: RTL
=================

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter W, default 8, giving the LFSR length in bits (3..32).
REQ-002 SHALL have parameter POLY, default 9'h11D, W+1 bits wide, giving the characteristic polynomial; POLY[W] and POLY[0] SHALL be 1.
REQ-003 SHALL have parameter NB, default 1, giving the bits generated/checked per enabled cycle (1..W).
REQ-004 SHALL have parameter SEED, default 1, giving the nonzero generator reset state.
REQ-005 SHALL have parameter LOCK_CNT, default 16, giving the consecutive matching checker cycles needed to lock.
REQ-006 SHALL have parameter LOSS_CNT, default 4, giving the consecutive mismatching checker cycles that drop lock.
REQ-007 SHALL have port clk  in  1  clock, rising edge.
REQ-008 SHALL have port arst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port en  in  1  advance generator by NB steps.
REQ-010 SHALL have port seed_ld  in  1  load generator state from seed.
REQ-011 SHALL have port seed  in  W  seed value.
REQ-012 SHALL have port out  out  NB  next NB generator bits, out[0] first.
REQ-013 SHALL have port chk_en  in  1  chk_in valid this cycle.
REQ-014 SHALL have port chk_in  in  NB  received bits, chk_in[0] first.
REQ-015 SHALL have port err_clr  in  1  clear err_cnt.
REQ-016 SHALL have port locked  out  1  checker in LOCKED state.
REQ-017 SHALL have port err_pulse  out  1  one-cycle flag: bit error(s) detected while locked.
REQ-018 SHALL have port err_cnt  out  16  saturating bit-error count.

Function
REQ-019 SHALL implement one Galois step as: bit=sreg[0]; sreg <= bit ? (sreg>>1)^(POLY>>1) : sreg>>1.
REQ-020 SHALL drive out[i] combinationally as the bit of step i (i=0..NB-1) starting from the current sreg; for NB=1, out=sreg[0].
REQ-021 SHALL advance sreg by NB steps per clock with en=1, and hold sreg with en=0.
REQ-022 SHALL give seed_ld priority over en; loaded value = seed, or 1 when seed==0 (lock-up avoidance).
REQ-023 SHALL keep checker history hist of the last W received bits; predicted bit = XOR over j=1..W of POLY[j] AND bit received j positions earlier.
REQ-024 SHALL process chk_in bits serially within a cycle (chk_in[0] first) and ignore chk_in when chk_en=0; all checker state holds then.
REQ-025 SHALL implement checker states HUNT and LOCKED.
REQ-026 HUNT: first ceil(W/NB) chk_en cycles after entry fill hist with no comparison; each later cycle compares every bit against its prediction and shifts received bits into hist.
REQ-027 HUNT: an all-match cycle increments match_cnt; any mismatch clears match_cnt; the LOCK_CNT-th consecutive match -> LOCKED, with locked=1 from the next cycle.
REQ-028 LOCKED: hist shifts in predicted bits (free-running), so each channel error counts once with no error multiplication.
REQ-029 LOCKED: cycle with k>0 mismatching bits -> err_pulse=1 next cycle; err_cnt += k, saturating at 16'hFFFF.
REQ-030 LOCKED: LOSS_CNT consecutive chk_en cycles each containing a mismatch -> HUNT (fill restarts, match_cnt=0); a clean cycle clears the loss counter.
REQ-031 err_clr SHALL zero err_cnt next cycle, taking priority over a simultaneous increment; err_cnt SHALL not change in HUNT.

Reset
REQ-032 arst=1 SHALL set sreg=SEED, checker=HUNT, hist=0, fill/match/loss counters=0, locked=0, err_pulse=0, err_cnt=0; arst overrides seed_ld, en, chk_en and err_clr.
REQ-033 arst asserted mid-operation SHALL discard lock and counts; operation restarts cleanly on the first cycle after deassertion.

Verification
REQ-034 W=8, POLY=0x11D, NB=1, reset then en=1 -> out over cycles 1,0,1,1,0,0,0,1; sreg after first step 0x8E; sequence period 255.
REQ-035 NB=4, same polynomial -> out=4'b1101 (bits 1,0,1,1) then 4'b1000; sreg 0x01 -> 0xD8 after one enabled cycle.
REQ-036 seed_ld=1 with seed=0 and en=1 -> sreg=0x01, no step that cycle; seed=0xA5 -> sreg=0xA5.
REQ-037 Loopback out->chk_in, chk_en=en=1, NB=1 -> locked=1 exactly 8+16 enabled cycles after reset release; err_cnt stays 0.
REQ-038 Locked loopback, invert one bit -> single err_pulse, err_cnt=1, still locked; invert 4 consecutive cycles -> locked drops, relocks 24 cycles after the corruption ends.
REQ-039 Locked, force err_cnt to 0xFFFF via errors -> holds 0xFFFF; err_clr with a simultaneous error -> 0.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// PRBS generator (Galois LFSR, NB bits per enabled cycle) plus a self-synchronising
// checker that hunts for lock on received data, then free-runs and counts bit errors.
module prbs_gen_chk #(
    parameter int             W        = 8,
    parameter logic [W:0]     POLY     = 9'h11D,
    parameter int             NB       = 1,
    parameter logic [W-1:0]   SEED     = {{(W-1){1'b0}}, 1'b1},
    parameter int             LOCK_CNT = 16,
    parameter int             LOSS_CNT = 4
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          seed_ld,
    input  logic [W-1:0]  seed,
    output logic [NB-1:0] out,
    input  logic          chk_en,
    input  logic [NB-1:0] chk_in,
    input  logic          err_clr,
    output logic          locked,
    output logic          err_pulse,
    output logic [15:0]   err_cnt
);

    localparam int FILL = (W + NB - 1) / NB;
    localparam int FW   = $clog2(FILL + 1);
    localparam int MW   = $clog2(LOCK_CNT + 1);
    localparam int LW   = $clog2(LOSS_CNT + 1);
    localparam int KW   = $clog2(NB + 1);

    localparam logic [FW-1:0] FILL_DONE  = FW'(FILL);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_CNT - 1);
    localparam logic [W-1:0]  TAPS       = POLY[W:1];
    localparam logic [W-1:0]  ONE        = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // ---------------- generator ----------------
    logic [W-1:0] sreg;
    logic [W-1:0] gen_walk;
    logic [W-1:0] sreg_step;

    always_comb begin
        gen_walk = sreg;
        out      = '0;
        for (int i = 0; i < NB; i++) begin
            out[i]   = gen_walk[0];
            gen_walk = gen_walk[0] ? ((gen_walk >> 1) ^ TAPS) : (gen_walk >> 1);
        end
        sreg_step = gen_walk;
    end

    // An all-zero state would lock the LFSR up, so a zero seed loads 1 instead.
    always_ff @(posedge clk) begin
        if (arst) begin
            sreg <= SEED;
        end else if (seed_ld) begin
            sreg <= (seed == '0) ? ONE : seed;
        end else if (en) begin
            sreg <= sreg_step;
        end
    end

    // ---------------- checker ----------------
    chk_state_t    state, state_nxt;
    logic [W-1:0]  hist, hist_nxt, chk_walk;
    logic [FW-1:0] fill_cnt, fill_nxt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic [LW-1:0] loss_cnt, loss_nxt;
    logic [NB-1:0] pred, miss;
    logic [KW-1:0] err_k;
    logic [16:0]   err_sum;
    logic          pulse_nxt;
    logic [15:0]   cnt_nxt;

    // hist[j-1] holds the bit seen j positions earlier; when locked it is fed with
    // its own predictions so a channel error never propagates into later predictions.
    always_comb begin
        chk_walk = hist;
        pred     = '0;
        miss     = '0;
        err_k    = '0;
        for (int i = 0; i < NB; i++) begin
            pred[i]  = ^(chk_walk & TAPS);
            miss[i]  = chk_in[i] ^ pred[i];
            chk_walk = {chk_walk[W-2:0], (state == LOCKED) ? pred[i] : chk_in[i]};
            err_k    = err_k + KW'(miss[i]);
        end
        err_sum = {1'b0, err_cnt} + 17'(err_k);
    end

    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        loss_nxt  = loss_cnt;
        pulse_nxt = 1'b0;
        cnt_nxt   = err_cnt;
        if (chk_en) begin
            hist_nxt = chk_walk;
            case (state)
                HUNT: begin
                    if (fill_cnt != FILL_DONE) begin
                        fill_nxt = fill_cnt + FW'(1);
                    end else if (miss == '0) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + MW'(1);
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (miss != '0) begin
                        pulse_nxt = 1'b1;
                        cnt_nxt   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                        if (loss_cnt == LOSS_LAST) begin
                            state_nxt = HUNT;
                            fill_nxt  = '0;
                            match_nxt = '0;
                            loss_nxt  = '0;
                        end else begin
                            loss_nxt = loss_cnt + LW'(1);
                        end
                    end else begin
                        loss_nxt = '0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (err_clr) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= HUNT;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            loss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            hist      <= hist_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            loss_cnt  <= loss_nxt;
            err_pulse <= pulse_nxt;
            err_cnt   <= cnt_nxt;
        end
    end

    assign locked = (state == LOCKED);

endmodule
